// File: rtl/billiard_pkg.sv
// Shared types and widths for the billiard ball datapath.
// Used by the ball motion engine, its axis integrators and the hit controller.
package billiard_pkg;

   localparam int VEL_W         = 11;
   localparam int POS_INT_W     = 11;
   localparam int POS_FRAC_BITS = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROLLING  = 2'd1,
      SINKING  = 2'd2,
      POCKETED = 2'd3
   } ball_state_t;

   // Unsigned fixed-point position: integer pixels above POS_FRAC_BITS fraction bits.
   typedef logic [POS_INT_W+POS_FRAC_BITS-1:0] pos_fp_t;
   typedef logic signed [VEL_W-1:0]            vel_t;

endpackage

// File: rtl/ball_motion_if.sv
// Bundle of frame, shot, collision and hole signals into one ball, plus its kinematic outputs.
// The slave side is the ball itself; the master side is whoever drives it.
interface ball_motion_if;
   import billiard_pkg::*;

   logic                 startOfFrame;
   logic                 shotValid;
   vel_t                 shotVelX;
   vel_t                 shotVelY;
   logic                 collisionOccurred;
   vel_t                 velXIn;
   vel_t                 velYIn;
   logic                 holeHit;
   logic [2:0]           holeNum;
   logic                 respawn;
   logic [POS_INT_W-1:0] topLeftX;
   logic [POS_INT_W-1:0] topLeftY;
   vel_t                 velX;
   vel_t                 velY;
   logic                 moving;
   logic                 inHole;
   logic [2:0]           holeNumOut;

   modport master (
      output startOfFrame, shotValid, shotVelX, shotVelY, collisionOccurred,
             velXIn, velYIn, holeHit, holeNum, respawn,
      input  topLeftX, topLeftY, velX, velY, moving, inHole, holeNumOut
   );

   modport slave (
      input  startOfFrame, shotValid, shotVelX, shotVelY, collisionOccurred,
             velXIn, velYIn, holeHit, holeNum, respawn,
      output topLeftX, topLeftY, velX, velY, moving, inHole, holeNumOut
   );

endinterface

// File: rtl/ball_axis_integrator.sv
// One axis of ball kinematics: fixed-point position, signed velocity,
// saturating integration and friction decay with a stop threshold.
module ball_axis_integrator import billiard_pkg::*; #(
   parameter int INIT           = 100,
   parameter int MAX            = 607,
   parameter int FRAC_BITS      = 6,
   parameter int FRICTION_SHIFT = 5,
   parameter int STOP_THRESH    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 integrate,
   input  logic                 load,
   input  logic                 freeze,
   input  logic                 respawn,
   input  vel_t                 load_vel,
   output logic [POS_INT_W-1:0] pos_int,
   output vel_t                 vel,
   output logic                 stop
);

   localparam int POS_W = POS_INT_W + FRAC_BITS;
   localparam int SUM_W = POS_W + 2;
   localparam logic [POS_W-1:0]        INIT_FP = POS_W'(INIT * (2 ** FRAC_BITS));
   localparam logic signed [SUM_W-1:0] MAX_FP  = SUM_W'(MAX * (2 ** FRAC_BITS));
   localparam vel_t                    THRESH  = VEL_W'(STOP_THRESH);

   logic [POS_W-1:0]        pos;
   logic [POS_W-1:0]        pos_next;
   logic signed [SUM_W-1:0] sum;
   vel_t                    vel_fric;
   vel_t                    vel_next;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      sum = $signed({2'b00, pos}) + $signed({{(SUM_W-VEL_W){vel[VEL_W-1]}}, vel});
      if (sum < 0)
         pos_next = '0;
      else if (sum > MAX_FP)
         pos_next = POS_W'(MAX_FP);
      else
         pos_next = sum[POS_W-1:0];
      // Arithmetic shift rounds toward minus infinity, so negative speeds always shrink.
      vel_fric = vel - (vel >>> FRICTION_SHIFT);
      stop     = (vel_fric < THRESH) && (vel_fric > -THRESH);
      vel_next = stop ? '0 : vel_fric;
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pos <= INIT_FP;
         vel <= '0;
      end else if (respawn) begin
         pos <= INIT_FP;
         vel <= '0;
      end else if (!freeze) begin
         if (integrate)
            pos <= pos_next;
         if (load)
            vel <= load_vel;
         else if (integrate)
            vel <= vel_next;
      end
   end

   assign pos_int = pos[FRAC_BITS +: POS_INT_W];

endmodule

// File: rtl/ball_motion.sv
// Per-ball kinematics engine: shot/collision capture, per-frame motion with friction,
// and the sink/pocket/respawn sequence. resetN is synchronous and active-high.
module ball_motion import billiard_pkg::*; #(
   parameter int INIT_X         = 100,
   parameter int INIT_Y         = 200,
   parameter int X_MAX          = 607,
   parameter int Y_MAX          = 447,
   parameter int FRAC_BITS      = 6,
   parameter int FRICTION_SHIFT = 5,
   parameter int STOP_THRESH    = 2,
   parameter int SINK_FRAMES    = 16
) (
   input logic          clk,
   input logic          resetN,
   ball_motion_if.slave bus
);

   localparam logic [1:0] S_IDLE     = IDLE;
   localparam logic [1:0] S_ROLLING  = ROLLING;
   localparam logic [1:0] S_SINKING  = SINKING;
   localparam logic [1:0] S_POCKETED = POCKETED;
   localparam int CNT_W = $clog2(SINK_FRAMES + 1);

   logic [1:0]           state;
   logic                 armed;
   logic [CNT_W-1:0]     sink_cnt;
   logic [2:0]           hole_num;
   logic                 active, hole_take, capture, shot_take;
   logic                 integrate, vel_load, respawn_take;
   vel_t                 load_vel_x, load_vel_y;
   vel_t                 vel_x, vel_y;
   logic [POS_INT_W-1:0] pos_x, pos_y;
   logic                 stop_x, stop_y;

   // holeHit outranks a same-cycle collision, and a collision outranks a shot.
   always_comb begin
      active       = (state == S_IDLE) || (state == S_ROLLING);
      hole_take    = active && bus.holeHit;
      capture      = active && !bus.holeHit && bus.collisionOccurred && armed;
      shot_take    = (state == S_IDLE) && bus.shotValid && !bus.holeHit && !capture;
      integrate    = (state == S_ROLLING) && bus.startOfFrame && !bus.holeHit;
      vel_load     = hole_take || capture || shot_take;
      respawn_take = (state == S_POCKETED) && bus.respawn;
      load_vel_x   = '0;
      load_vel_y   = '0;
      if (capture) begin
         load_vel_x = bus.velXIn;
         load_vel_y = bus.velYIn;
      end else if (shot_take) begin
         load_vel_x = bus.shotVelX;
         load_vel_y = bus.shotVelY;
      end
   end

   always_ff @(posedge clk) begin
      if (resetN) begin
         state    <= S_IDLE;
         armed    <= 1'b1;
         sink_cnt <= '0;
         hole_num <= '0;
      end else begin
         // A new frame rearms capture even if it coincides with one.
         if (bus.startOfFrame)
            armed <= 1'b1;
         else if (capture)
            armed <= 1'b0;

         case (state)
            S_IDLE, S_ROLLING: begin
               if (hole_take) begin
                  state    <= S_SINKING;
                  sink_cnt <= CNT_W'(SINK_FRAMES);
                  hole_num <= bus.holeNum;
               end else if (capture || shot_take) begin
                  state <= S_ROLLING;
               end else if (integrate && stop_x && stop_y) begin
                  state <= S_IDLE;
               end
            end
            S_SINKING: begin
               if (bus.startOfFrame) begin
                  if (sink_cnt <= CNT_W'(1)) begin
                     sink_cnt <= '0;
                     state    <= S_POCKETED;
                  end else begin
                     sink_cnt <= sink_cnt - CNT_W'(1);
                  end
               end
            end
            S_POCKETED: begin
               if (bus.respawn) begin
                  state    <= S_IDLE;
                  hole_num <= '0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   ball_axis_integrator #(
      .INIT(INIT_X), .MAX(X_MAX), .FRAC_BITS(FRAC_BITS),
      .FRICTION_SHIFT(FRICTION_SHIFT), .STOP_THRESH(STOP_THRESH)
   ) u_axis_x (
      .clk(clk), .rst(resetN), .integrate(integrate), .load(vel_load),
      .freeze(!active), .respawn(respawn_take), .load_vel(load_vel_x),
      .pos_int(pos_x), .vel(vel_x), .stop(stop_x)
   );

   ball_axis_integrator #(
      .INIT(INIT_Y), .MAX(Y_MAX), .FRAC_BITS(FRAC_BITS),
      .FRICTION_SHIFT(FRICTION_SHIFT), .STOP_THRESH(STOP_THRESH)
   ) u_axis_y (
      .clk(clk), .rst(resetN), .integrate(integrate), .load(vel_load),
      .freeze(!active), .respawn(respawn_take), .load_vel(load_vel_y),
      .pos_int(pos_y), .vel(vel_y), .stop(stop_y)
   );

   assign bus.topLeftX   = pos_x;
   assign bus.topLeftY   = pos_y;
   assign bus.velX       = vel_x;
   assign bus.velY       = vel_y;
   assign bus.moving     = (state == S_ROLLING);
   assign bus.inHole     = (state == S_SINKING) || (state == S_POCKETED);
   assign bus.holeNumOut = hole_num;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios with literal expectations
// plus randomized traffic against a behavioural model of one ball.
module tb_ball_motion;
   import billiard_pkg::*;

   localparam int INIT_X = 100;
   localparam int INIT_Y = 200;
   localparam int X_MAX  = 607;
   localparam int Y_MAX  = 447;
   localparam int FP     = 64;
   localparam int SINK   = 16;

   logic clk = 1'b0;
   logic resetN = 1'b1;

   ball_motion_if bus();

   ball_motion dut (.clk(clk), .resetN(resetN), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   typedef enum {M_IDLE, M_ROLL, M_SINK, M_POCK} mstate_t;
   mstate_t m_st;
   int      m_px, m_py, m_vx, m_vy, m_cnt, m_hole;
   bit      m_armed;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Friction written as floor division: v - floor(v/32), then a dead band |v| < 2.
   function automatic int decay(input int v);
      int loss, r;
      loss = (v >= 0) ? v / 32 : -((-v + 31) / 32);
      r = v - loss;
      if (r > -2 && r < 2) r = 0;
      return r;
   endfunction

   function automatic int clamp(input int p, input int hi);
      return (p < 0) ? 0 : ((p > hi) ? hi : p);
   endfunction

   // Advance the model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      mstate_t st0;
      bit captured;
      if (resetN) begin
         m_st = M_IDLE; m_px = INIT_X * FP; m_py = INIT_Y * FP;
         m_vx = 0; m_vy = 0; m_armed = 1'b1; m_cnt = 0; m_hole = 0;
         return;
      end
      st0 = m_st;
      captured = 1'b0;
      case (st0)
         M_IDLE, M_ROLL: begin
            if (bus.holeHit) begin
               m_st = M_SINK; m_vx = 0; m_vy = 0; m_hole = int'(bus.holeNum); m_cnt = SINK;
            end else begin
               captured = bus.collisionOccurred && m_armed;
               if (st0 == M_ROLL && bus.startOfFrame) begin
                  m_px = clamp(m_px + m_vx, X_MAX * FP);
                  m_py = clamp(m_py + m_vy, Y_MAX * FP);
                  if (!captured) begin
                     m_vx = decay(m_vx);
                     m_vy = decay(m_vy);
                     if (m_vx == 0 && m_vy == 0) m_st = M_IDLE;
                  end
               end
               if (captured) begin
                  m_vx = int'(bus.velXIn); m_vy = int'(bus.velYIn); m_st = M_ROLL;
               end else if (st0 == M_IDLE && bus.shotValid) begin
                  m_vx = int'(bus.shotVelX); m_vy = int'(bus.shotVelY); m_st = M_ROLL;
               end
            end
         end
         M_SINK: if (bus.startOfFrame) begin
            m_cnt--;
            if (m_cnt == 0) m_st = M_POCK;
         end
         M_POCK: if (bus.respawn) begin
            m_st = M_IDLE; m_px = INIT_X * FP; m_py = INIT_Y * FP;
            m_vx = 0; m_vy = 0; m_hole = 0;
         end
      endcase
      if (bus.startOfFrame) m_armed = 1'b1;
      else if (captured) m_armed = 1'b0;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("topLeftX",   int'(bus.topLeftX),   m_px / FP);
         check("topLeftY",   int'(bus.topLeftY),   m_py / FP);
         check("velX",       int'(bus.velX),       m_vx);
         check("velY",       int'(bus.velY),       m_vy);
         check("moving",     int'(bus.moving),     int'(m_st == M_ROLL));
         check("inHole",     int'(bus.inHole),     int'(m_st == M_SINK || m_st == M_POCK));
         check("holeNumOut", int'(bus.holeNumOut), m_hole);
      end
   end

   task automatic idle_inputs();
      bus.startOfFrame = 1'b0; bus.shotValid = 1'b0;
      bus.shotVelX = '0; bus.shotVelY = '0;
      bus.collisionOccurred = 1'b0; bus.velXIn = '0; bus.velYIn = '0;
      bus.holeHit = 1'b0; bus.holeNum = '0; bus.respawn = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      resetN = 1'b1; tick(); resetN = 1'b0;
   endtask

   task automatic shot(input int vx, input int vy);
      bus.shotValid = 1'b1; bus.shotVelX = vel_t'(vx); bus.shotVelY = vel_t'(vy);
      tick(); idle_inputs();
   endtask

   task automatic collide(input int vx, input int vy, input bit sof);
      bus.collisionOccurred = 1'b1; bus.velXIn = vel_t'(vx); bus.velYIn = vel_t'(vy);
      bus.startOfFrame = sof;
      tick(); idle_inputs();
   endtask

   task automatic frames(input int n);
      repeat (n) begin
         bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0; tick();
      end
   endtask

   initial begin
      idle_inputs();
      resetN = 1'b1;
      tick();
      cmp_en = 1'b1;
      tick();
      resetN = 1'b0;

      // Reset state
      check("rst_x", int'(bus.topLeftX), 100);
      check("rst_y", int'(bus.topLeftY), 200);
      check("rst_moving", int'(bus.moving), 0);

      // Shot and first frame of decay
      shot(128, 0);
      frames(1);
      check("shot_x", int'(bus.topLeftX), 102);
      check("shot_velx", int'(bus.velX), 124);
      check("shot_moving", int'(bus.moving), 1);

      // Negative shot decays all the way to rest
      do_reset();
      shot(-128, 0);
      frames(1);
      check("neg_x", int'(bus.topLeftX), 98);
      check("neg_velx", int'(bus.velX), -124);
      for (int i = 0; i < 400 && bus.moving; i++) frames(1);
      check("stop_moving", int'(bus.moving), 0);
      check("stop_velx", int'(bus.velX), 0);

      // Saturation at both walls, no wraparound
      do_reset();
      shot(-1024, 1023);
      frames(150);
      check("wall_x0", int'(bus.topLeftX), 0);
      check("wall_ymax", int'(bus.topLeftY), 447);

      // One capture per frame; next frame captures again
      do_reset();
      shot(128, 0);
      frames(1);
      collide(-64, 0, 1'b0);
      collide(-20, 0, 1'b0);
      collide(5, 0, 1'b0);
      check("dedup_velx", int'(bus.velX), -64);
      frames(1);
      check("dedup_fric", int'(bus.velX), -62);
      collide(100, 0, 1'b0);
      check("next_frame_cap", int'(bus.velX), 100);

      // Capture coincident with startOfFrame: old velocity integrates, no friction
      do_reset();
      shot(64, 0);
      collide(-128, 0, 1'b1);
      check("simul_x", int'(bus.topLeftX), 101);
      check("simul_velx", int'(bus.velX), -128);

      // Pocketing sequence
      do_reset();
      shot(200, 100);
      frames(1);
      bus.holeHit = 1'b1; bus.holeNum = 3'd3;
      bus.collisionOccurred = 1'b1; bus.velXIn = vel_t'(77);
      tick(); idle_inputs();
      check("hole_velx", int'(bus.velX), 0);
      check("hole_in", int'(bus.inHole), 1);
      check("hole_num", int'(bus.holeNumOut), 3);
      frames(15);
      bus.respawn = 1'b1; tick(); idle_inputs();
      check("sink_no_respawn", int'(bus.inHole), 1);
      frames(1);
      shot(300, 0);
      check("pocket_shot_ign", int'(bus.moving), 0);
      bus.respawn = 1'b1; tick(); idle_inputs();
      check("respawn_x", int'(bus.topLeftX), 100);
      check("respawn_y", int'(bus.topLeftY), 200);
      check("respawn_in", int'(bus.inHole), 0);
      check("respawn_num", int'(bus.holeNumOut), 0);

      // Reset in the middle of SINKING with capture disarmed beforehand
      do_reset();
      shot(50, 0);
      collide(30, 0, 1'b0);
      bus.holeHit = 1'b1; bus.holeNum = 3'd5; tick(); idle_inputs();
      do_reset();
      check("mid_rst_in", int'(bus.inHole), 0);
      check("mid_rst_num", int'(bus.holeNumOut), 0);
      check("mid_rst_x", int'(bus.topLeftX), 100);
      collide(40, -7, 1'b0);
      check("mid_rst_armed", int'(bus.velX), 40);
      check("mid_rst_moving", int'(bus.moving), 1);

      // Randomized traffic against the model
      for (int n = 0; n < 6000; n++) begin
         bus.startOfFrame      = ($urandom_range(0, 5) == 0);
         bus.shotValid         = ($urandom_range(0, 15) == 0);
         bus.shotVelX          = vel_t'($urandom_range(0, 2047));
         bus.shotVelY          = vel_t'($urandom_range(0, 2047));
         bus.collisionOccurred = ($urandom_range(0, 9) == 0);
         bus.velXIn            = vel_t'($urandom_range(0, 2047));
         bus.velYIn            = vel_t'($urandom_range(0, 2047));
         bus.holeHit           = ($urandom_range(0, 119) == 0);
         bus.holeNum           = 3'($urandom_range(0, 7));
         bus.respawn           = ($urandom_range(0, 9) == 0);
         resetN                = ($urandom_range(0, 499) == 0);
         tick();
      end
      idle_inputs();
      resetN = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-ball kinematics engine and the consumer of the hit controller's collision outputs. Holds one ball's fixed-point position and velocity, applies cue shots and collision velocities, integrates motion once per video frame with friction decay, and runs the pocketing sequence when the ball reaches a hole. One instance per ball. Its position and velocity outputs feed both the ball drawer and the hit controller inputs.

## Interface
Parameters:
- INIT_X, 100: respawn/reset top-left X, pixels
- INIT_Y, 200: respawn/reset top-left Y, pixels
- X_MAX, 607: maximum top-left X, pixels; position saturates to [0, X_MAX]
- Y_MAX, 447: maximum top-left Y, pixels; position saturates to [0, Y_MAX]
- FRAC_BITS, 6: fractional bits of position; velocity is in units of 2^-FRAC_BITS px/frame
- FRICTION_SHIFT, 5: per-frame decay, vel -= vel >>> FRICTION_SHIFT
- STOP_THRESH, 2: |vel| below this after decay is forced to 0
- SINK_FRAMES, 16: frames spent in SINKING

Ports:
- clk  in  1  system clock
- resetN  in  1  one clock; reset is synchronous and active-high (asserted = 1 despite the suffix)
- startOfFrame  in  1  one-cycle pulse per frame
- shotValid  in  1  cue shot request
- shotVelX, shotVelY  in  11 signed  shot velocity
- collisionOccurred  in  1  hit controller collision flag
- velXIn, velYIn  in  11 signed  post-collision velocity from the hit controller
- holeHit  in  1  ball overlaps a hole
- holeNum  in  3  hole index qualified by holeHit
- respawn  in  1  return a pocketed ball to the table
- topLeftX, topLeftY  out  11  integer pixel position
- velX, velY  out  11 signed  current velocity
- moving  out  1  state is ROLLING
- inHole  out  1  state is SINKING or POCKETED
- holeNumOut  out  3  latched hole index

## Operation
- States: IDLE, ROLLING, SINKING, POCKETED.
- Position registers hold 11+FRAC_BITS bits, unsigned fixed point. Outputs topLeftX/Y are the integer part.
- IDLE: velocity is 0. On shotValid, load shotVel* and go to ROLLING. shotValid in any other state is ignored.
- IDLE or ROLLING, collision capture:
  - Load velXIn/velYIn on the first cycle of collisionOccurred within each frame.
  - An armed flag is set at startOfFrame and cleared on capture. Later pulses in the same frame are ignored.
  - A capture in IDLE moves the state to ROLLING.
- ROLLING, on startOfFrame:
  - pos += sign-extended vel, then saturate to [0, X_MAX<<FRAC_BITS] (same rule for Y).
  - Per axis: vel -= vel >>> FRICTION_SHIFT. If |result| < STOP_THRESH, vel = 0.
  - If both axes are 0 after the update, go to IDLE.
- Simultaneous startOfFrame and collision capture: position integrates using the old velocity, the velocity register takes the captured value (friction is skipped that frame), and the armed flag is rearmed.
- holeHit in IDLE or ROLLING:
  - Go to SINKING, zero velocity, latch holeNum, load the frame counter with SINK_FRAMES.
  - holeHit takes priority over a same-cycle collision or shot.
- SINKING: position frozen. Collisions and shots are ignored. Counter decrements on each startOfFrame; at 0, go to POCKETED.
- POCKETED: position frozen. On respawn, position = INIT, velocity = 0, go to IDLE. holeNumOut is held until respawn.
- Reset, including mid-sequence: state IDLE, position INIT_X/INIT_Y, velX/velY = 0, moving = 0, inHole = 0, holeNumOut = 0, armed = 1, counter = 0.

## Timing
- All outputs are registered.
- An event sampled at edge N (shot, capture, holeHit, respawn) is visible on the outputs after edge N.
- Position for frame F is updated at the edge that samples startOfFrame, so it is stable for the whole frame.
- moving and inHole are decoded from the registered state, so they change in the same cycle as the state.
- No backpressure. Single-cycle inputs are sufficient.

## Structure
- Shared package billiard_pkg holds:
  - ball_state_t enum (IDLE, ROLLING, SINKING, POCKETED)
  - VEL_W = 11, POS_INT_W = 11
  - a fixed-point position typedef parameterised by FRAC_BITS
- Sub-module ball_axis_integrator, instantiated twice (X, Y):
  - Per-axis position/velocity registers, load, saturating add, friction and stop threshold.
  - Controls: integrate enable, load enable, freeze.
- The FSM, armed flag and frame counter live in ball_motion.

## Test plan
- Shot and decay: reset, shotVelX = 128, shotVelY = 0, one startOfFrame -> topLeftX = 102, velX = 124, moving = 1. Repeated frames -> velX reaches 0, state IDLE, moving = 0.
- Negative velocity with wall saturation: X = 1, vel = -256, one frame -> topLeftX = 0 (saturated), no wraparound.
- Per-frame collision dedup: ROLLING, collisionOccurred high 3 cycles with velXIn = -64, -20, 5 -> velX = -64 only. The next frame's capture succeeds.
- Simultaneous startOfFrame and collision: velX = 64, collision velXIn = -128 on the same cycle -> X += 1, velX = -128 with no friction applied.
- Pocketing: holeHit with holeNum = 3 while ROLLING, plus a same-cycle collision -> velocity 0, inHole = 1, holeNumOut = 3. After 16 frames the state is POCKETED. shotValid is ignored. respawn -> position INIT, IDLE.
- Reset mid-SINKING -> all outputs at reset values next cycle, armed = 1.
